branch_sequencer: RTL

- Sequences one conditional branch (BEQ/BNE/BLT/BGE/BLTU/BGEU) from issue through to resolution.
- Accepts a branch from decode and evaluates its condition.
- Then either retires it as not-taken, issues a fetch redirect to the target, or raises a trap.
- Raises instruction-address-misaligned only when the branch is taken, as the ISA requires. This replaces the unconditional alignment check in the combinational branch datapath.
- Sits between decode/issue, fetch (redirect port) and the trap unit.

---
 rtl/branch_sequencer_if.sv | 49 ++++
 rtl/branch_sequencer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if
//   Bundles the request, redirect, trap, retire and performance-counter
//   signals of the branch sequencer.
//   Ports (signals):
//     req_*        : branch request from decode (valid/ready + operands)
//     redirect_*   : fetch redirect (valid/ready + target pc)
//     exception_*  : trap request (valid/ready + cause/tval)
//     done_*       : one-cycle retire pulse with architectural next pc
//     perf_*       : taken / not-taken / trap event counters
//   Modports: slave = the sequencer, master = its surroundings.
interface branch_sequencer_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_pc;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_immediate;
  logic [XLEN-1:0] req_rs1_value;
  logic [XLEN-1:0] req_rs2_value;
  logic            redirect_valid;
  logic            redirect_ready;
  logic [XLEN-1:0] redirect_pc;
  logic            exception_valid;
  logic            exception_ready;
  logic [3:0]      exception_cause;
  logic [XLEN-1:0] exception_tval;
  logic            done_valid;
  logic [XLEN-1:0] done_next_pc;
  logic [31:0]     perf_taken_count;
  logic [31:0]     perf_not_taken_count;
  logic [31:0]     perf_trap_count;

  modport slave (
    input  req_valid, req_pc, req_funct3, req_immediate, req_rs1_value,
           req_rs2_value, redirect_ready, exception_ready,
    output req_ready, redirect_valid, redirect_pc, exception_valid,
           exception_cause, exception_tval, done_valid, done_next_pc,
           perf_taken_count, perf_not_taken_count, perf_trap_count
  );

  modport master (
    output req_valid, req_pc, req_funct3, req_immediate, req_rs1_value,
           req_rs2_value, redirect_ready, exception_ready,
    input  req_ready, redirect_valid, redirect_pc, exception_valid,
           exception_cause, exception_tval, done_valid, done_next_pc,
           perf_taken_count, perf_not_taken_count, perf_trap_count
  );
endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer
//   Takes one conditional branch from decode, evaluates it, then retires it
//   as not-taken, redirects fetch to the target, or raises a trap. The
//   misaligned-target trap is raised only for taken branches.
//   Ports:
//     clk   : clock
//     reset : asynchronous, active-high reset
//     bus   : branch_sequencer_if.slave (request, redirect, trap, retire,
//             performance counters)
//   Optional feature macro: BRANCH_SEQUENCER_PERF_COUNTERS_EN
//     defined   -> taken / not-taken / trap counters are live (wrap at 2^32)
//     undefined -> perf_* outputs are tied to zero
//
//   state    | meaning
//   IDLE     | ready for a new branch; retire pulse may be showing
//   EVALUATE | latched branch is being resolved (single cycle)
//   REDIRECT | taken branch waiting for fetch to accept the target
//   TRAP     | illegal or misaligned branch waiting for the trap unit
module branch_sequencer #(
  parameter int XLEN             = 32,
  parameter int MISALIGNED_CAUSE = 0,
  parameter int ILLEGAL_CAUSE    = 2
) (
  input logic              clk,
  input logic              reset,
  branch_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EVALUATE, REDIRECT, TRAP} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, imm_q, rs1_q, rs2_q;
  logic [2:0]      funct3_q;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [3:0]      cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic            done_valid_q, done_valid_d;
  logic [XLEN-1:0] done_next_pc_q, done_next_pc_d;
  logic [XLEN-1:0] target, fallthrough;
  logic            taken, illegal, accept;

  assign target      = pc_q + imm_q;
  assign fallthrough = pc_q + XLEN'(4);
  assign illegal     = (funct3_q == 3'b010) || (funct3_q == 3'b011);
  assign accept      = (state_q == IDLE) && bus.req_valid;

  always_comb begin
    taken = 1'b0;
    case (funct3_q)
      3'b000: taken = (rs1_q == rs2_q);
      3'b001: taken = (rs1_q != rs2_q);
      3'b100: taken = ($signed(rs1_q) <  $signed(rs2_q));
      3'b101: taken = ($signed(rs1_q) >= $signed(rs2_q));
      3'b110: taken = (rs1_q <  rs2_q);
      3'b111: taken = (rs1_q >= rs2_q);
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    redirect_pc_d  = redirect_pc_q;
    cause_d        = cause_q;
    tval_d         = tval_q;
    done_valid_d   = 1'b0;
    done_next_pc_d = done_next_pc_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = EVALUATE;
      end
      EVALUATE: begin
        // An undefined funct3 traps before the condition is even considered.
        if (illegal) begin
          state_d = TRAP;
          cause_d = 4'(ILLEGAL_CAUSE);
          tval_d  = '0;
        end else if (taken && (target[1:0] != 2'b00)) begin
          state_d = TRAP;
          cause_d = 4'(MISALIGNED_CAUSE);
          tval_d  = target;
        end else if (taken) begin
          state_d       = REDIRECT;
          redirect_pc_d = target;
        end else begin
          state_d        = IDLE;
          done_valid_d   = 1'b1;
          done_next_pc_d = fallthrough;
        end
      end
      REDIRECT: begin
        if (bus.redirect_ready) begin
          state_d        = IDLE;
          done_valid_d   = 1'b1;
          done_next_pc_d = redirect_pc_q;
        end
      end
      TRAP: begin
        if (bus.exception_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q           <= '0;
      imm_q          <= '0;
      rs1_q          <= '0;
      rs2_q          <= '0;
      funct3_q       <= '0;
      redirect_pc_q  <= '0;
      cause_q        <= '0;
      tval_q         <= '0;
      done_valid_q   <= 1'b0;
      done_next_pc_q <= '0;
    end else begin
      if (accept) begin
        pc_q     <= bus.req_pc;
        imm_q    <= bus.req_immediate;
        rs1_q    <= bus.req_rs1_value;
        rs2_q    <= bus.req_rs2_value;
        funct3_q <= bus.req_funct3;
      end
      redirect_pc_q  <= redirect_pc_d;
      cause_q        <= cause_d;
      tval_q         <= tval_d;
      done_valid_q   <= done_valid_d;
      done_next_pc_q <= done_next_pc_d;
    end
  end

  assign bus.req_ready       = (state_q == IDLE);
  assign bus.redirect_valid  = (state_q == REDIRECT);
  assign bus.redirect_pc     = redirect_pc_q;
  assign bus.exception_valid = (state_q == TRAP);
  assign bus.exception_cause = cause_q;
  assign bus.exception_tval  = tval_q;
  assign bus.done_valid      = done_valid_q;
  assign bus.done_next_pc    = done_next_pc_q;

`ifdef BRANCH_SEQUENCER_PERF_COUNTERS_EN
  logic [31:0] taken_cnt_q, not_taken_cnt_q, trap_cnt_q;
  logic        redirect_hs, trap_hs, not_taken_retire;

  assign redirect_hs      = (state_q == REDIRECT) && bus.redirect_ready;
  assign trap_hs          = (state_q == TRAP) && bus.exception_ready;
  assign not_taken_retire = (state_q == EVALUATE) && (state_d == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
      trap_cnt_q      <= '0;
    end else begin
      if (redirect_hs)      taken_cnt_q     <= taken_cnt_q + 32'd1;
      if (not_taken_retire) not_taken_cnt_q <= not_taken_cnt_q + 32'd1;
      if (trap_hs)          trap_cnt_q      <= trap_cnt_q + 32'd1;
    end
  end

  assign bus.perf_taken_count     = taken_cnt_q;
  assign bus.perf_not_taken_count = not_taken_cnt_q;
  assign bus.perf_trap_count      = trap_cnt_q;
`else
  assign bus.perf_taken_count     = '0;
  assign bus.perf_not_taken_count = '0;
  assign bus.perf_trap_count      = '0;
`endif

endmodule
